// File: rtl/booth_mul_pkg.sv
// Shared constants, Booth digit encoding and compressor-tree sizing helpers
// for the pipelined radix-4 Booth multiplier.
package booth_mul_pkg;

  // Edges from the accepting edge to the edge that raises out_valid.
  localparam int LAT = 4;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_e;

  function automatic int ew_of(input int width);
    return width + 2;
  endfunction

  function automatic int nd_of(input int width);
    return (width + 2) / 2;
  endfunction

  // Row count after one level of 3:2 compression.
  function automatic int csa_rows(input int n);
    return (n / 3) * 2 + n % 3;
  endfunction

  function automatic int rows_after(input int n, input int levels);
    int m;
    m = n;
    for (int i = 0; i < 16; i++)
      if (i < levels) m = csa_rows(m);
    return m;
  endfunction

  function automatic int levels_to4(input int n);
    int m;
    int lv;
    m = n;
    lv = 0;
    for (int i = 0; i < 16; i++)
      if (m > 4) begin
        m = csa_rows(m);
        lv++;
      end
    return lv;
  endfunction

  // Triplet is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_e booth_digit(input logic [2:0] triplet);
    booth_digit_e d;
    case (triplet)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_mul_pipe_pp_gen.sv
// One Booth partial-product row: selects 0, +-a or +-2a from a recoded triplet.
module booth_pp_gen
  import booth_mul_pkg::*;
#(
  parameter int EW = 34
) (
  input  logic [EW-1:0] a_ext_i,
  input  logic [2:0]    triplet_i,
  output logic [EW:0]   row_o,
  output logic          neg_o,
  output logic          comp_o
);

  booth_digit_e dig;
  logic [EW:0]  mag;

  // Negative digits emit the one's complement; the +1 rides in neg_o.
  always_comb begin
    dig = booth_digit(triplet_i);
    mag = '0;
    case (dig)
      POS1, NEG1: mag = {a_ext_i[EW-1], a_ext_i};
      POS2, NEG2: mag = {a_ext_i, 1'b0};
      default:    mag = '0;
    endcase
    neg_o  = (dig == NEG1) || (dig == NEG2);
    row_o  = neg_o ? ~mag : mag;
    comp_o = ~row_o[EW];
  end

endmodule

// File: rtl/booth_mul_pipe.sv
// Pipelined radix-4 Booth multiplier: operand capture, three compressor
// stages and a final 4:2 + carry-propagate stage, with a global stall enable.
module booth_mul_pipe
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_signed,
  input  logic               b_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int EW = ew_of(WIDTH);
  localparam int ND = nd_of(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam int NR = ND + 1;
  localparam int IW = $clog2(NR);
  localparam int R1 = csa_rows(NR);
  localparam int LT = levels_to4(R1);
  localparam int L2 = (LT + 1) / 2;
  localparam int L3 = LT - L2;
  localparam int R2 = rows_after(R1, L2);

  typedef logic [PW-1:0]          vec_t;
  typedef logic [NR-1:0][PW-1:0]  rows_t;
  typedef logic [IW-1:0]          idx_t;

  function automatic vec_t maj(input vec_t x, input vec_t y, input vec_t z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Sum of the -2^(EW+1) terms that complete each row's 1-prefix sign extension.
  function automatic vec_t comp_const();
    vec_t acc;
    acc = '0;
    for (int i = 0; i < ND; i++) acc = acc + (vec_t'(1) << (EW + 1 + 2 * i));
    return -acc;
  endfunction

  localparam vec_t COMP_K = comp_const();

  function automatic rows_t csa_level(input rows_t r, input int n);
    rows_t o;
    int    base;
    o    = '0;
    base = 2 * (n / 3);
    for (int g = 0; g < NR / 3; g++)
      if (3 * g + 2 < n) begin
        o[idx_t'(2 * g)]     = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
        o[idx_t'(2 * g + 1)] = maj(r[3*g], r[3*g+1], r[3*g+2]) << 1;
      end
    for (int i = 0; i < NR; i++)
      if (i >= 3 * (n / 3) && i < n) o[idx_t'(base + i - 3 * (n / 3))] = r[i];
    return o;
  endfunction

  function automatic rows_t reduce(input rows_t r, input int n, input int levels);
    rows_t o;
    int    m;
    o = r;
    m = n;
    for (int lv = 0; lv < 16; lv++)
      if (lv < levels) begin
        o = csa_level(o, m);
        m = csa_rows(m);
      end
    return o;
  endfunction

  // Handshake: a beat moves on a port when valid && ready on the same rising
  // edge; the whole pipe advances only when the output slot is empty or drains.
  logic                    en;
  logic [LAT:0]            vld_q;
  logic [LAT:0][TAG_W-1:0] tag_q;
  vec_t                    prod_q, prod_d;

  assign en        = !vld_q[LAT] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[LAT];
  assign out_tag   = tag_q[LAT];
  assign product   = prod_q;

  logic [EW-1:0] op_a_q, op_a_d;
  logic [EW:0]   op_b_q, op_b_d;

  assign op_a_d = {{2{a_signed & a[WIDTH-1]}}, a};
  assign op_b_d = {{2{b_signed & b[WIDTH-1]}}, b, 1'b0};

  logic [ND-1:0] neg;
  rows_t         pp_rows;
  vec_t          corr;

  for (genvar i = 0; i < ND; i++) begin : g_pp
    logic [EW:0] row;
    logic        comp;
    booth_pp_gen #(.EW(EW)) u_pp (
      .a_ext_i   (op_a_q),
      .triplet_i (op_b_q[2*i+2:2*i]),
      .row_o     (row),
      .neg_o     (neg[i]),
      .comp_o    (comp)
    );
    assign pp_rows[i] = vec_t'({comp, row}) << (2 * i);
  end

  // Negate bits sit at even columns below EW+1, so they share a row with COMP_K.
  always_comb begin
    corr = COMP_K;
    for (int i = 0; i < ND; i++) corr[2*i] = neg[i];
  end
  assign pp_rows[ND] = corr;

  rows_t s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  vec_t  t_s, t_c, f_s, f_c;

  assign s1_d = csa_level(pp_rows, NR);
  assign s2_d = reduce(s1_q, R1, L2);
  assign s3_d = reduce(s2_q, R2, L3);

  always_comb begin
    t_s    = s3_q[0] ^ s3_q[1] ^ s3_q[2];
    t_c    = maj(s3_q[0], s3_q[1], s3_q[2]) << 1;
    f_s    = t_s ^ t_c ^ s3_q[3];
    f_c    = maj(t_s, t_c, s3_q[3]) << 1;
    prod_d = f_s + f_c;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      tag_q  <= '0;
      prod_q <= '0;
    end else if (en) begin
      vld_q  <= {vld_q[LAT-1:0], in_valid};
      tag_q  <= {tag_q[LAT-1:0], in_tag};
      prod_q <= prod_d;
    end
  end

endmodule

// File: tb/tb_booth_mul_pipe.sv
// Bench for booth_mul_pipe: directed corners, stall, mid-flight reset and
// randomised streams on a 32-bit and an 8-bit instance.
module tb_booth_mul_pipe;

  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int PW  = 2 * W;
  localparam int W8  = 8;
  localparam int PW8 = 2 * W8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_ready, a_signed = 1'b0, b_signed = 1'b0;
  logic          out_valid, out_ready = 1'b1;
  logic [W-1:0]  a = '0, b = '0;
  logic [TW-1:0] in_tag = '0, out_tag;
  logic [PW-1:0] product;

  logic           in_valid8 = 1'b0, in_ready8, a_signed8 = 1'b0, b_signed8 = 1'b0;
  logic           out_valid8, out_ready8 = 1'b1;
  logic [W8-1:0]  a8 = '0, b8 = '0;
  logic [TW-1:0]  in_tag8 = '0, out_tag8;
  logic [PW8-1:0] product8;

  booth_mul_pipe #(.WIDTH(W), .TAG_W(TW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .out_tag(out_tag)
  );

  booth_mul_pipe #(.WIDTH(W8), .TAG_W(TW)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .a_signed(a_signed8), .b_signed(b_signed8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8), .product(product8), .out_tag(out_tag8)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_out    = 0;
  int n_out8   = 0;
  int last_acc = 0;
  bit done     = 1'b0;

  logic [TW+PW-1:0]  exp_q[$];
  logic [TW+PW8-1:0] exp8_q[$];

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [PW-1:0] ref32(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic xs, input logic ys);
    logic signed [W+1:0]   ex, ey;
    logic signed [2*W+3:0] p;
    ex = {{2{xs & x[W-1]}}, x};
    ey = {{2{ys & y[W-1]}}, y};
    p  = ex * ey;
    return p[PW-1:0];
  endfunction

  function automatic logic [PW8-1:0] ref8(input logic [W8-1:0] x, input logic [W8-1:0] y,
                                          input logic xs, input logic ys);
    logic signed [W8+1:0]   ex, ey;
    logic signed [2*W8+3:0] p;
    ex = {{2{xs & x[W8-1]}}, x};
    ey = {{2{ys & y[W8-1]}}, y};
    p  = ex * ey;
    return p[PW8-1:0];
  endfunction

  // Scoreboard monitors: an output transfer pops and compares the oldest entry.
  always @(negedge clk) begin
    logic [TW+PW-1:0] e;
    #1;
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      n_out++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out32_unexpected: got tag=%0d product=%h, required no output", out_tag, product);
      end else begin
        e = exp_q.pop_front();
        if ({out_tag, product} !== e) begin
          n_fail++;
          $display("FAIL out32_result: got tag=%0d product=%h, required tag=%0d product=%h",
                   out_tag, product, e[TW+PW-1:PW], e[PW-1:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [TW+PW8-1:0] e;
    #1;
    if (rst_n && out_valid8 && out_ready8) begin
      n_checks++;
      n_out8++;
      if (exp8_q.size() == 0) begin
        n_fail++;
        $display("FAIL out8_unexpected: got tag=%0d product=%h, required no output", out_tag8, product8);
      end else begin
        e = exp8_q.pop_front();
        if ({out_tag8, product8} !== e) begin
          n_fail++;
          $display("FAIL out8_result: got tag=%0d product=%h, required tag=%0d product=%h",
                   out_tag8, product8, e[TW+PW8-1:PW8], e[PW8-1:0]);
        end
      end
    end
  end

  // Drivers: called at a falling edge, hold the beat until accepted.
  task automatic send32(input logic [W-1:0] x, input logic [W-1:0] y, input logic xs,
                        input logic ys, input logic [TW-1:0] t, input logic [PW-1:0] exp_p);
    int guard;
    guard    = 0;
    a        = x;
    b        = y;
    a_signed = xs;
    b_signed = ys;
    in_tag   = t;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send32_ready: in_ready=%b after %0d cycles, required 1", in_ready, guard);
    end else begin
      exp_q.push_back({t, exp_p});
      last_acc = cyc + 1;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send8(input logic [W8-1:0] x, input logic [W8-1:0] y, input logic xs,
                       input logic ys, input logic [TW-1:0] t);
    int guard;
    guard     = 0;
    a8        = x;
    b8        = y;
    a_signed8 = xs;
    b_signed8 = ys;
    in_tag8   = t;
    in_valid8 = 1'b1;
    #1;
    while (!in_ready8 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    n_checks++;
    if (!in_ready8) begin
      n_fail++;
      $display("FAIL send8_ready: in_ready=%b after %0d cycles, required 1", in_ready8, guard);
    end else begin
      exp8_q.push_back({t, ref8(x, y, xs, ys)});
    end
    @(negedge clk);
    in_valid8 = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || exp8_q.size() != 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    ok = (exp_q.size() == 0 && exp8_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (product !== '0) begin n_fail++; $display("FAIL reset_product: got %h, required 0", product); end
    if (out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag: got %0d, required 0", out_tag); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8: got %b, required 0", out_valid8); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_max();
    int  g, acc;
    bit  ok;
    out_ready = 1'b1;
    send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd1, 64'hFFFF_FFFE_0000_0001);
    acc = last_acc;
    g   = 0;
    #1;
    while (!out_valid && g < 10) begin
      @(negedge clk);
      #1;
      g++;
    end
    n_checks++;
    if (!out_valid || cyc - acc != 4) begin
      n_fail++;
      $display("FAIL latency: out_valid=%b at %0d edges after accept, required 1 at 4", out_valid, cyc - acc);
    end
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL drain_unsigned: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_signed_mixed();
    bit ok;
    send32(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 4'd2, 64'h4000_0000_0000_0000);
    send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'd3, 64'h0000_0000_0000_0001);
    send32(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd4, 64'hFFFF_FFFE_0000_0002);
    send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd5, 64'hFFFF_FFFF_0000_0001);
    send32(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 4'd6, 64'h0);
    send32(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 4'd7, 64'hC000_0000_8000_0000);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL drain_signed: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int               out_start;
    logic [PW-1:0]    cap_p;
    logic [TW-1:0]    cap_t;
    bit               ok;
    out_start = n_out;
    out_ready = 1'b1;
    fork
      begin
        for (int t = 0; t < 6; t++) begin
          logic [W-1:0] x, y;
          x = 32'h1234_5678 + 32'(t) * 32'h0101_1111;
          y = 32'hF0F0_0F0F ^ 32'(t * 77);
          send32(x, y, t[0], t[1], TW'(t), ref32(x, y, t[0], t[1]));
        end
      end
      begin
        int g;
        g = 0;
        #1;
        while (!out_valid && g < 20) begin
          @(negedge clk);
          #1;
          g++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        n_checks += 2;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: got %b, required 1", out_valid); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
        cap_p = product;
        cap_t = out_tag;
        for (int k = 1; k < 3; k++) begin
          @(negedge clk);
          #1;
          n_checks += 3;
          if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
          if (product !== cap_p) begin n_fail++; $display("FAIL stall_product: got %h, required %h", product, cap_p); end
          if (out_tag !== cap_t) begin n_fail++; $display("FAIL stall_out_tag: got %0d, required %0d", out_tag, cap_t); end
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drain(ok);
    n_checks += 2;
    if (!ok) begin n_fail++; $display("FAIL drain_backpressure: %0d outstanding, required 0", exp_q.size()); end
    if (n_out - out_start != 6) begin
      n_fail++;
      $display("FAIL backpressure_count: got %0d outputs, required 6", n_out - out_start);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send32(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 4'd9, 64'd15);
    send32(32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 1'b0, 4'd10, 64'h0000_00DE_ADBE_EF00);
    send32(32'hFFFF_FFF0, 32'h0000_0002, 1'b1, 1'b0, 4'd11, 64'hFFFF_FFFF_FFFF_FFE0);
    rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b, required 0", out_valid); end
    if (product !== '0) begin n_fail++; $display("FAIL midreset_product: got %h, required 0", product); end
    if (out_tag !== '0) begin n_fail++; $display("FAIL midreset_out_tag: got %0d, required 0", out_tag); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b, required 1", in_ready); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_stale: out_valid=%b tag=%0d at cycle %0d after reset, required 0", out_valid, out_tag, k);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random32();
    logic [W-1:0] corners [4];
    bit ok;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'hFFFF_FFFF;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic [W-1:0] x, y;
          logic         xs, ys;
          x  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
          y  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
          xs = 1'($urandom_range(0, 1));
          ys = 1'($urandom_range(0, 1));
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send32(x, y, xs, ys, TW'(i), ref32(x, y, xs, ys));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL drain_random32: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_random8();
    bit ok;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic [W8-1:0] x, y;
          x = 8'($urandom_range(0, 255));
          y = 8'($urandom_range(0, 255));
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send8(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'(i));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready8 = ($urandom_range(0, 2) != 0);
          @(negedge clk);
        end
        out_ready8 = 1'b1;
      end
    join
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL drain_random8: %0d outstanding, required 0", exp8_q.size()); end
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: time limit reached before end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_mixed();
    test_backpressure();
    test_reset_mid();
    test_random32();
    test_random8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mul_pipe.md
# booth_mul_pipe

Parametrised, fully pipelined radix-4 Booth multiplier with Wallace-tree reduction, a per-operand signed/unsigned mode and valid/ready flow control with backpressure. It is the next-generation datapath multiplier for the arithmetic cluster. It accepts one operand pair per cycle and returns the exact 2·WIDTH-bit product after a fixed four-cycle latency. A tag travels alongside each operation for out-of-band bookkeeping.

## Interface
- WIDTH, 32: operand width. Must be even and ≥ 8.
- TAG_W, 4: width of the sideband tag carried with each operation. Must be ≥ 1.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: operand pair valid.
- in_ready, output, 1: block can accept; a transfer occurs when in_valid && in_ready.
- a, input, WIDTH: multiplicand.
- b, input, WIDTH: multiplier.
- a_signed, input, 1: 1 = a is two's complement; 0 = a is unsigned.
- b_signed, input, 1: 1 = b is two's complement; 0 = b is unsigned.
- in_tag, input, TAG_W: sideband tag, returned unchanged with the result.
- out_valid, output, 1: product valid.
- out_ready, input, 1: consumer accepts; a transfer occurs when out_valid && out_ready.
- product, output, 2·WIDTH: exact product, two's complement if either operand is signed.
- out_tag, output, TAG_W: tag belonging to the current product.

## Operation
- **Operand extension.** Each operand is extended to EW = WIDTH+2 bits, using sign extension if its signed flag is 1 and zero extension otherwise. This makes every signed/unsigned mix exact.
- **Booth recoding.** b is recoded into ND = EW/2 radix-4 digits in {−2,−1,0,+1,+2}, taken from bit triplets {b[2i+1], b[2i], b[2i−1]} with b[−1] = 0.
- **Partial products.** Each digit selects 0, ±a or ±2a. Negation is done by inversion plus a correction bit injected at the digit's LSB column. Sign extension uses the constant "1-prefix" compensation, so each row is EW+1 bits wide plus compensation bits.
- **Reduction.** Rows are reduced with 3:2 and 4:2 compressors into sum/carry vectors truncated to 2·WIDTH bits. Arithmetic is modulo 2^(2·WIDTH), so carries out of the top column are discarded.
- **Pipeline stages.**
  - S1: recode, partial-product generation and first compressor level; registers the sum/carry groups.
  - S2: second compressor level.
  - S3: third level, down to 3–4 vectors.
  - S4: final 4:2 compression plus a carry-propagate add, registered into product.
- **Per-stage sideband.** Each stage carries a valid bit and the tag.
- **Flow control.** A single global enable advances the whole pipeline: en = !out_valid || out_ready, and in_ready = en.
  - When en = 0, every stage register, valid bit and tag holds.
  - Bubbles are not collapsed.
- **Stage valid bits.** A stage's valid bit loads its predecessor's valid bit when en = 1. The S1 valid bit loads in_valid && in_ready.
- **Transfer-free cycles.** Stage data registers may load freely while invalid. Only the valid bits are architecturally significant.

## Timing
- **Latency.** An operation accepted at edge k has out_valid = 1 after edge k+4, provided out_ready was 1 throughout.
- **Throughput.** One operation per cycle when out_ready is held at 1.
- **Stall.** out_valid && !out_ready stalls the whole pipeline. While stalled:
  - in_ready = 0 in the same cycle (combinational from out_ready).
  - product and out_tag hold stable.
- **Simultaneous accept and drain.** When out_valid && out_ready && in_valid, the output drains and the input is accepted on the same edge.
- **Reset values.** Asserting rst_n = 0:
  - clears all valid bits, out_valid = 0, product = 0, out_tag = 0, in_ready = 1 (after reset, the pipeline is empty).
  - Operations in flight are discarded without an output.
  - Deassertion is synchronised externally. The first accept may occur on the first edge after deassertion.
- **Ordering.** Products emerge in acceptance order. Each operation produces exactly one output transfer; none is lost or duplicated.

## Structure
- **Package booth_mul_pkg:**
  - constants EW and ND as functions of WIDTH;
  - LAT = 4;
  - the Booth digit enum {ZERO, POS1, POS2, NEG1, NEG2};
  - function booth_digit(triplet).
- **Sub-module booth_pp_gen.** Parametrised on EW; one instance per digit, generated. Inputs: extended a and the triplet. Outputs: the EW+1-bit row, the negate bit and the sign-compensation bits.
- **Compressors.** The existing C32 and C42 compressor cells are reused. The column layout is produced by generate loops over ND, not hand-written per WIDTH.

## Test plan
- **Unsigned maximum.** WIDTH=32, a_signed=0, b_signed=0, a=b=0xFFFFFFFF -> product 0xFFFFFFFE00000001, out_valid exactly 4 cycles after accept.
- **Signed corners.** Both signed: a=b=0x80000000 -> 0x4000000000000000; a=b=0xFFFFFFFF -> 0x0000000000000001.
- **Mixed signedness.** a_signed=1, b_signed=0, a=0xFFFFFFFE, b=0xFFFFFFFF -> 0xFFFFFFFE00000002.
- **Backpressure.** Stream 6 operations back-to-back with tags 0..5 and hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, product/out_tag stable, all 6 results delivered in tag order, none lost or duplicated.
- **Reset mid-operation.** Accept 3 operations, assert rst_n=0 for 1 cycle -> out_valid=0 and product=0 immediately; no stale result emerges within 8 following cycles.
- **Random regression.** WIDTH ∈ {8, 16, 32}, random modes, random in_valid/out_ready -> every product matches a reference model.
